recf32_recode_arbiter: RTL and testbench

//  Shares one float32-to-recoded-float32 converter among N requesters. A round-robin arbiter

---
 rtl/recode_pkg.sv | 21 ++
 rtl/float32ToRecodedFloat32.sv | 48 ++++
 rtl/rr_arbiter.sv | 35 +++
 rtl/recf32_recode_arbiter.sv | 108 ++++++++++
 tb/tb_recf32_recode_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/recode_pkg.sv
// Shared widths, recoded-exponent constants and queue entry type for the recode arbiter.
package recode_pkg;

  localparam int unsigned FLOAT32_W = 32;
  localparam int unsigned RECF32_W  = 33;
  localparam int unsigned SRC_W_MAX = 3;
  localparam int unsigned TAG_W_MAX = 16;

  localparam logic [8:0] REC_EXP_BIAS_ADJ = 9'h081;
  localparam logic [8:0] REC_EXP_SUB_ADJ  = 9'h082;
  localparam logic [8:0] REC_EXP_INF      = 9'h180;
  localparam logic [8:0] REC_EXP_NAN      = 9'h1C0;

  // Sized for the largest supported N and tag; the top slices down to its parameters.
  typedef struct packed {
    logic [RECF32_W-1:0]  recf32;
    logic [SRC_W_MAX-1:0] src;
    logic [TAG_W_MAX-1:0] tag;
  } rec_entry_t;

endpackage

// File: rtl/float32ToRecodedFloat32.sv
// Combinational IEEE float32 to 33-bit recoded float32 converter.
module float32ToRecodedFloat32
  import recode_pkg::*;
(
  input  logic [FLOAT32_W-1:0] i_f32,
  output logic [RECF32_W-1:0]  o_rec
);

  logic        w_sign;
  logic [7:0]  w_exp;
  logic [22:0] w_fract;
  logic [4:0]  w_lzc;
  logic [22:0] w_norm;
  logic [8:0]  w_rexp;
  logic [22:0] w_rfract;
  logic        w_unused_norm;

  assign w_sign  = i_f32[31];
  assign w_exp   = i_f32[30:23];
  assign w_fract = i_f32[22:0];

  always_comb begin
    w_lzc = '0;
    for (int i = 0; i < 23; i++) begin
      if (w_fract[i]) w_lzc = 5'(22 - i);
    end
  end

  // Subnormals: shift the leading one out to become the implicit bit.
  assign w_norm        = w_fract << w_lzc;
  assign w_unused_norm = w_norm[22];

  always_comb begin
    w_rexp   = '0;
    w_rfract = w_fract;
    if (w_exp == 8'hFF) begin
      w_rexp = (w_fract == '0) ? REC_EXP_INF : REC_EXP_NAN;
    end else if (w_exp != '0) begin
      w_rexp = {1'b0, w_exp} + REC_EXP_BIAS_ADJ;
    end else if (w_fract != '0) begin
      w_rexp   = ~{4'b0, w_lzc} + REC_EXP_SUB_ADJ;
      w_rfract = {w_norm[21:0], 1'b0};
    end
  end

  assign o_rec = {w_sign, w_rexp, w_rfract};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic             i_en,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [IDX_W-1:0] w_j;

  // Scan from farthest to nearest so the closest request to ptr is the last write.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = '0;
    if (i_en) begin
      for (int k = int'(N) - 1; k >= 0; k--) begin
        w_j = IDX_W'((int'(i_ptr) + k) % int'(N));
        if (i_req[w_j]) begin
          o_grant      = '0;
          o_grant[w_j] = 1'b1;
          o_idx        = w_j;
          o_valid      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/recf32_recode_arbiter.sv
// Shares one float32 recoder among N requesters; results go through a 2-entry in-order queue.
module recf32_recode_arbiter
  import recode_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N-1:0]           req_valid,
  output logic [N-1:0]           req_ready,
  input  logic [N*FLOAT32_W-1:0] req_data,
  input  logic [N*TAG_W-1:0]     req_tag,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [RECF32_W-1:0]    resp_data,
  output logic [$clog2(N)-1:0]   resp_src,
  output logic [TAG_W-1:0]       resp_tag
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [N-1:0]         w_grant;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_push;
  logic                 w_pop;
  logic [FLOAT32_W-1:0] w_operand;
  logic [TAG_W-1:0]     w_tag;
  logic [RECF32_W-1:0]  w_rec;
  logic [1:0]           w_count_d;
  rec_entry_t           w_entry;
  rec_entry_t           w_head;
  logic                 w_unused_head;

  logic [IDX_W-1:0]     r_ptr;
  logic [1:0]           r_count;
  logic                 r_accept_en;
  logic                 r_wr;
  logic                 r_rd;
  rec_entry_t           r_q [2];

  rr_arbiter #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_en    (r_accept_en),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_push)
  );

  assign req_ready = w_grant;

  always_comb begin
    w_operand = '0;
    w_tag     = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (w_grant[i]) begin
        w_operand = req_data[FLOAT32_W*i +: FLOAT32_W];
        w_tag     = req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  float32ToRecodedFloat32 u_conv (
    .i_f32 (w_operand),
    .o_rec (w_rec)
  );

  assign w_entry.recf32 = w_rec;
  assign w_entry.src    = SRC_W_MAX'(w_idx);
  assign w_entry.tag    = TAG_W_MAX'(w_tag);

  assign w_pop     = (r_count != '0) & resp_ready;
  assign w_count_d = r_count + {1'b0, w_push} - {1'b0, w_pop};

  // Accept enable is registered so req_ready never sees resp_ready combinationally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_ptr       <= '0;
      r_accept_en <= 1'b0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_q[0]      <= '0;
      r_q[1]      <= '0;
    end else begin
      r_count     <= w_count_d;
      r_accept_en <= (w_count_d != 2'd2);
      if (w_push) begin
        r_q[r_wr] <= w_entry;
        r_wr      <= ~r_wr;
        r_ptr     <= (w_idx == IDX_W'(N - 1)) ? '0 : w_idx + 1'b1;
      end
      if (w_pop) r_rd <= ~r_rd;
    end
  end

  assign w_head        = r_q[r_rd];
  assign resp_valid    = (r_count != '0);
  assign resp_data     = w_head.recf32;
  assign resp_src      = w_head.src[IDX_W-1:0];
  assign resp_tag      = w_head.tag[TAG_W-1:0];
  assign w_unused_head = ^{w_head.src, w_head.tag};

endmodule

// File: tb/tb_recf32_recode_arbiter.sv
// Directed bench for recf32_recode_arbiter with a cycle model and result scoreboard.
module tb_recf32_recode_arbiter;

  logic         clock;
  logic         reset_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_data;
  logic [19:0]  req_tag;
  logic         resp_valid;
  logic         resp_ready;
  logic [32:0]  resp_data;
  logic [1:0]   resp_src;
  logic [4:0]   resp_tag;

  int n_checks = 0;
  int n_fails  = 0;

  logic [39:0] sb [$];
  int          m_count = 0;
  int          m_ptr   = 0;
  bit          mon_on  = 0;
  int          mon_g;
  int          mon_j;
  logic [3:0]  mon_er;
  int          acc;

  logic [31:0] vals [5] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'h7FC00000,
                            32'h00000001};
  logic [32:0] exps [5] = '{33'h0_0000_0000, 33'h1_0000_0000, 33'h0_C000_0000,
                            33'h0_E040_0000, 33'h0_3580_0000};

  recf32_recode_arbiter #(
    .N     (4),
    .TAG_W (5)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_src   (resp_src),
    .resp_tag   (resp_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Reference recoder: subnormals normalised by repeated shifting.
  function automatic logic [32:0] model_rec(input logic [31:0] f);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [23:0] mm;
    int          k;
    s = f[31];
    e = f[30:23];
    m = f[22:0];
    if (e == 8'hFF) return (m == '0) ? {s, 9'h180, 23'h0} : {s, 9'h1C0, m};
    if (e == 8'h00 && m == '0) return {s, 32'h0};
    if (e != 8'h00) return {s, {1'b0, e} + 9'h081, m};
    mm = {1'b0, m};
    k  = 0;
    while (!mm[23]) begin
      mm = mm << 1;
      k++;
    end
    return {s, 9'(130 - k), mm[22:0]};
  endfunction

  always @(negedge clock) begin
    if (mon_on && reset_n) begin
      mon_g = -1;
      if (m_count < 2) begin
        for (int k = 0; k < 4; k++) begin
          mon_j = (m_ptr + k) % 4;
          if (mon_g < 0 && req_valid[mon_j]) mon_g = mon_j;
        end
      end
      mon_er = (mon_g >= 0) ? 4'(1 << mon_g) : 4'b0;
      chk("req_ready", 64'(req_ready), 64'(mon_er));
      chk("resp_valid", 64'(resp_valid), 64'(m_count != 0));
      if (m_count != 0 && sb.size() > 0) begin
        chk("resp_data", 64'(resp_data), 64'(sb[0][39:7]));
        chk("resp_src", 64'(resp_src), 64'(sb[0][6:5]));
        chk("resp_tag", 64'(resp_tag), 64'(sb[0][4:0]));
      end
      if (m_count != 0 && resp_ready) begin
        void'(sb.pop_front());
        m_count--;
      end
      if (mon_g >= 0) begin
        sb.push_back({model_rec(req_data[32*mon_g +: 32]), 2'(mon_g), req_tag[5*mon_g +: 5]});
        m_count++;
        m_ptr = (mon_g + 1) % 4;
      end
    end
  end

  initial begin
    reset_n    = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_tag    = '0;
    resp_ready = 1'b0;
    #1 reset_n = 1'b0;
    #1 req_valid = 4'hF;
    #1;
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset resp_data", 64'(resp_data), 64'd0);
    chk("reset resp_src", 64'(resp_src), 64'd0);
    chk("reset resp_tag", 64'(resp_tag), 64'd0);
    @(posedge clock);
    @(posedge clock);
    #3;
    chk("reset hold req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    reset_n   = 1'b1;
    cyc();
    mon_on = 1;

    // Single request, one-cycle latency
    resp_ready     = 1'b1;
    req_data[31:0] = 32'h3F800000;
    req_tag[4:0]   = 5'd3;
    req_valid      = 4'b0001;
    cyc();
    req_valid = '0;
    chk("single valid", 64'(resp_valid), 64'd1);
    chk("single data", 64'(resp_data), 64'(33'h0_8000_0000));
    chk("single src", 64'(resp_src), 64'd0);
    chk("single tag", 64'(resp_tag), 64'd3);

    // Special values back to back on requester 3
    req_tag[19:15] = 5'd7;
    for (int k = 0; k < 5; k++) begin
      req_data[127:96] = vals[k];
      req_valid        = 4'b1000;
      cyc();
      chk("special data", 64'(resp_data), 64'(exps[k]));
    end
    req_valid = '0;
    cyc();

    // Fairness with all requesters valid
    for (int i = 0; i < 4; i++) begin
      req_data[32*i +: 32] = 32'h3F800000 + (i << 23);
      req_tag[5*i +: 5]    = 5'(10 + i);
    end
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #2;
      chk("rr grant", 64'(req_ready), 64'(1 << (k % 4)));
      cyc();
      chk("rr src", 64'(resp_src), 64'(k % 4));
    end
    req_valid = '0;
    cyc();

    // Backpressure: queue fills after two accepts
    resp_ready = 1'b0;
    req_valid  = 4'hF;
    acc        = 0;
    for (int k = 0; k < 6; k++) begin
      #2;
      if (req_ready != '0) acc++;
      cyc();
    end
    chk("bp accepts", 64'(acc), 64'd2);
    chk("bp full ready", 64'(req_ready), 64'd0);
    chk("bp head data", 64'(resp_data), 64'(33'h0_8000_0000));
    chk("bp head src", 64'(resp_src), 64'd0);
    resp_ready = 1'b1;
    #2;
    chk("bp pop cycle ready", 64'(req_ready), 64'd0);
    cyc();
    resp_ready = 1'b0;
    #2;
    chk("bp resume ready", 64'(req_ready), 64'(4'b0100));
    cyc();
    req_valid  = '0;
    resp_ready = 1'b1;
    cyc();
    cyc();
    cyc();

    // Simultaneous push and pop at count 1
    resp_ready     = 1'b0;
    req_data[31:0] = 32'h40400000;
    req_valid      = 4'b0001;
    cyc();
    resp_ready = 1'b1;
    req_valid  = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      req_data[63:32] = 32'h40400000 + k;
      req_tag[9:5]    = 5'(k);
      #2;
      chk("pp ready", 64'(req_ready), 64'(4'b0010));
      cyc();
      chk("pp valid", 64'(resp_valid), 64'd1);
    end
    req_valid = '0;
    cyc();
    cyc();

    // Asynchronous reset with a full queue
    resp_ready = 1'b0;
    req_valid  = 4'hF;
    cyc();
    cyc();
    #2;
    mon_on  = 0;
    reset_n = 1'b0;
    #1;
    chk("mid reset resp_valid", 64'(resp_valid), 64'd0);
    chk("mid reset resp_data", 64'(resp_data), 64'd0);
    chk("mid reset req_ready", 64'(req_ready), 64'd0);
    sb.delete();
    m_count   = 0;
    m_ptr     = 0;
    req_valid = 4'b0101;
    cyc();
    reset_n = 1'b1;
    cyc();
    mon_on = 1;
    #2;
    chk("post reset grant", 64'(req_ready), 64'(4'b0001));
    cyc();
    chk("post reset src", 64'(resp_src), 64'd0);
    req_valid  = '0;
    resp_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
